mux4_to_1: RTL and testbench
============================

Name: mux4_to_1

Overview:
- Four-input, one-output selector: `out` follows input `a`, `b`, `c` or `d` according to the 2-bit `sel`.
- Combinational path with zero latency; it is the primary function.
- A registered copy of the output and a saturating output-toggle counter are added. These feed switching-activity data into the power-estimation flow.
- Sits as a leaf cell in datapath muxing and power-characterisation benches.

Parameters:
- WIDTH, 1, bit width of each data input and of `out`/`out_q`.
- CNT_W, 16, width of the toggle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  data input selected when sel=2'b00.
- b  input  WIDTH  data input selected when sel=2'b01.
- c  input  WIDTH  data input selected when sel=2'b10.
- d  input  WIDTH  data input selected when sel=2'b11.
- sel  input  2  select code.
- clr_cnt  input  1  synchronous clear of toggle_cnt.
- out  output  WIDTH  combinational mux output.
- out_q  output  WIDTH  out registered by one clk.
- toggle_cnt  output  CNT_W  accumulated bit toggles of out_q.

Behaviour:
- Combinational output:
  - out = a when sel=00, b when 01, c when 10, d when 11.
  - Purely combinational, no clock dependency, no latency.
  - Valid whether or not reset is asserted.
- Decode style: fully specified case (or equivalent). No latches.
  - A default branch drives `a`, so sim X on sel never creates inferred storage.
- out_q:
  - On each rising clk, out_q <= out.
  - Latency exactly one cycle.
- toggle_cnt:
  - On each rising clk, toggle_cnt <= toggle_cnt + popcount(out ^ out_q), i.e. the number of bits of out_q that will change this edge.
  - Saturates at all-ones; never wraps.
  - The addition is done at CNT_W+1 bits, then clamped.
- clr_cnt:
  - When 1 at a rising edge, toggle_cnt <= 0. Clear has priority over increment in the same cycle.
  - out_q still updates normally.
- Reset (rst_n=0): immediately and asynchronously, out_q=0 and toggle_cnt=0.
- Release: on the first rising edge after rst_n rises, out_q captures out.
  - The toggle compared at that edge is against out_q=0.
- Reset mid-operation: the counter is lost. out remains live throughout.
- Simultaneous sel and data changes: out reflects the new combination after propagation. Only the value present at the clk edge is registered/counted.
- Glitches between edges are not counted.

Decomposition:
- Shared package: none required. Optional SEL_A..SEL_D localparams (2'b00..2'b11) for readability.
- Natural sub-module: popcount_sat_acc, a WIDTH-bit popcount plus a CNT_W saturating accumulator with clear. Instantiated once.
- Mux decode and out_q register stay in the top.

Test Plan:
- Combinational decode (WIDTH=1), each step 5 ns apart, check out after settle:
  - sel=00,a=1,b=0,c=1,d=1 -> out=1
  - sel=01,a=1,b=1,c=0,d=1 -> out=1
  - sel=00,a=0,b=0,c=1,d=1 -> out=0
  - sel=10,a=1,b=1,c=1,d=1 -> out=1
  - sel=11,a=1,b=0,c=1,d=0 -> out=0
  - sel=00,a=0,b=0,c=1,d=0 -> out=0
  - sel=10,a=1,b=0,c=0,d=1 -> out=0
  - sel=11,a=1,b=1,c=1,d=1 -> out=1
- Reset: hold rst_n=0 with a=1, sel=00 -> out=1, out_q=0, toggle_cnt=0. Release, one clk -> out_q=1, toggle_cnt=1.
- Toggle count: WIDTH=4, a=4'hF, b=4'h0, alternate sel 00/01 every clk for 10 clks after out_q settles -> toggle_cnt increments by 4 per clk, totalling 40.
- Saturation: CNT_W=4, toggle out every clk for 20 clks -> toggle_cnt reaches 15 and holds at 15.
- Clear priority: assert clr_cnt on a cycle where out toggles -> toggle_cnt=0 next cycle, out_q still updates.
- Async reset mid-run: drop rst_n between clk edges -> out_q and toggle_cnt go 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mux4_to_1_pkg.sv
// Shared select codes for the 4:1 mux leaf cell and its activity counter.
package mux4_to_1_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4_to_1_popcount_sat_acc.sv
// Counts set bits of a toggle vector and accumulates them into a saturating
// counter with synchronous clear.
module popcount_sat_acc #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] diff,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] next_cnt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{CNT_W{1'b0}}, diff[i]};
        end
        sum      = {1'b0, cnt} + pop;
        next_cnt = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Clear wins over the increment; the extra sum bit flags overflow for clamping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/mux4_to_1.sv
// Zero-latency 4:1 mux with a registered copy of the output and a saturating
// count of bit toggles on that registered copy for power estimation.
module mux4_to_1
    import mux4_to_1_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    // The default arm keeps an X select from looking like a hold condition.
    always_comb begin
        case (sel)
            SEL_A:   out = a;
            SEL_B:   out = b;
            SEL_C:   out = c;
            SEL_D:   out = d;
            default: out = a;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

    popcount_sat_acc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .diff  (out ^ out_q),
        .cnt   (toggle_cnt)
    );

endmodule

// File: tb/tb_mux4_to_1.sv
// Directed bench for mux4_to_1: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_mux4_to_1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 decode / reset instance
    logic       a1 = 0, b1 = 0, c1 = 0, d1 = 0;
    logic [1:0] sel1 = 2'b00;
    logic       clr1 = 1'b0;
    logic       out1, outq1;
    logic [15:0] cnt1;

    // WIDTH=4 toggle-count / clear instance
    logic [3:0] a4 = 4'hF, b4 = 4'h0, c4 = 4'h0, d4 = 4'h0;
    logic [1:0] sel4 = 2'b00;
    logic       clr4 = 1'b0;
    logic [3:0] out4, outq4;
    logic [15:0] cnt4;

    // CNT_W=4 saturation instance
    logic       as = 0, bs = 0, cs = 0, ds = 0;
    logic [1:0] sels = 2'b00;
    logic       clrs = 1'b0;
    logic       outs, outqs;
    logic [3:0] cnts;

    mux4_to_1 #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel1),
        .clr_cnt(clr1), .out(out1), .out_q(outq1), .toggle_cnt(cnt1)
    );

    mux4_to_1 #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .d(d4), .sel(sel4),
        .clr_cnt(clr4), .out(out4), .out_q(outq4), .toggle_cnt(cnt4)
    );

    mux4_to_1 #(.WIDTH(1), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .c(cs), .d(ds), .sel(sels),
        .clr_cnt(clrs), .out(outs), .out_q(outqs), .toggle_cnt(cnts)
    );

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic decode_step(input logic [1:0] s, input logic va, input logic vb,
                               input logic vc, input logic vd, input logic exp);
        sel1 = s; a1 = va; b1 = vb; c1 = vc; d1 = vd;
        expect_val($sformatf("decode_sel%0d", s), {31'd0, exp});
        #5;
        check({31'd0, out1});
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Combinational decode, running while reset is still asserted
        #2;
        decode_step(2'b00, 1, 0, 1, 1, 1);
        decode_step(2'b01, 1, 1, 0, 1, 1);
        decode_step(2'b00, 0, 0, 1, 1, 0);
        decode_step(2'b10, 1, 1, 1, 1, 1);
        decode_step(2'b11, 1, 0, 1, 0, 0);
        decode_step(2'b00, 0, 0, 1, 0, 0);
        decode_step(2'b10, 1, 0, 0, 1, 0);
        decode_step(2'b11, 1, 1, 1, 1, 1);

        // Reset state with a=1, sel=00
        sel1 = 2'b00; a1 = 1; b1 = 0; c1 = 0; d1 = 0;
        #1;
        expect_val("rst_out",    32'd1); check({31'd0, out1});
        expect_val("rst_out_q",  32'd0); check({31'd0, outq1});
        expect_val("rst_cnt",    32'd0); check({16'd0, cnt1});
        expect_val("rst_cnt4",   32'd0); check({16'd0, cnt4});

        // Release: first edge compares against out_q=0
        @(negedge clk);
        rst_n = 1'b1;
        edge_wait();
        expect_val("rel_out_q",  32'd1); check({31'd0, outq1});
        expect_val("rel_cnt",    32'd1); check({16'd0, cnt1});
        expect_val("rel_out_q4", 32'hF); check({28'd0, outq4});
        expect_val("rel_cnt4",   32'd4); check({16'd0, cnt4});

        // Alternate between a=F and b=0: four bit toggles per edge
        for (int k = 1; k <= 10; k++) begin
            sel4 = (k % 2 == 1) ? 2'b01 : 2'b00;
            edge_wait();
            expect_val($sformatf("tog_out_q4_%0d", k), (k % 2 == 1) ? 32'h0 : 32'hF);
            check({28'd0, outq4});
            expect_val($sformatf("tog_cnt4_%0d", k), 32'(4 + 4 * k));
            check({16'd0, cnt4});
        end
        expect_val("tog_total", 32'd40); check({16'd0, cnt4} - 32'd4);
        expect_val("idle_cnt1", 32'd1);  check({16'd0, cnt1});

        // Saturation on a 4-bit counter
        for (int k = 1; k <= 20; k++) begin
            as = ~as;
            edge_wait();
            expect_val($sformatf("sat_cnt_%0d", k), (k > 15) ? 32'd15 : 32'(k));
            check({28'd0, cnts});
        end

        // Clear has priority over a toggling edge; out_q still follows
        clr4 = 1'b1;
        sel4 = 2'b01;
        edge_wait();
        expect_val("clr_cnt4",   32'd0); check({16'd0, cnt4});
        expect_val("clr_out_q4", 32'h0); check({28'd0, outq4});
        clr4 = 1'b0;
        sel4 = 2'b00;
        edge_wait();
        expect_val("post_clr_cnt4",   32'd4); check({16'd0, cnt4});
        expect_val("post_clr_out_q4", 32'hF); check({28'd0, outq4});

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_out_q4", 32'h0); check({28'd0, outq4});
        expect_val("arst_cnt4",   32'd0); check({16'd0, cnt4});
        expect_val("arst_cnts",   32'd0); check({28'd0, cnts});
        expect_val("arst_out4",   32'hF); check({28'd0, out4});
        #10;
        rst_n = 1'b1;
        #10;

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
